lr35902_snd_wave: RTL and testbench

//  Voice 3 (wave) generator of the sound unit. Holds the 16x8 wave RAM (FF30-FF3F),

---
 rtl/lr35902_snd_pkg.sv | 25 ++
 rtl/lr35902_snd_wave_if.sv | 14 +
 rtl/lr35902_snd_wram.sv | 32 +++
 rtl/lr35902_snd_wave.sv | 92 +++++++++
 tb/tb_lr35902_snd_wave.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/lr35902_snd_pkg.sv
// Shared sound-unit definitions: register addresses, mixer silence level,
// and the NR32 volume shift/offset table with its helper.
// No ports; imported by every voice and the mixer.
package lr35902_snd_pkg;

  localparam logic [15:0] NR30_ADR  = 16'hFF1A;
  localparam logic [15:0] NR31_ADR  = 16'hFF1B;
  localparam logic [15:0] NR32_ADR  = 16'hFF1C;
  localparam logic [15:0] NR33_ADR  = 16'hFF1D;
  localparam logic [15:0] NR34_ADR  = 16'hFF1E;
  localparam logic [15:0] NR52_ADR  = 16'hFF26;
  localparam logic [15:0] WAVE_BASE = 16'hFF30;

  localparam logic [3:0] SILENCE = 4'd8;

  // Indexed by NR32[6:5]; entry 0 is never used because vol 0 is silence.
  localparam logic [7:0]  VOL_SHIFT = {2'd2, 2'd1, 2'd0, 2'd0};
  localparam logic [15:0] VOL_OFS   = {4'd6, 4'd4, 4'd0, 4'd0};

  // Attenuated sample, re-centred around SILENCE.
  function automatic logic [3:0] wave_level(input logic [3:0] s, input logic [1:0] vol);
    return (s >> VOL_SHIFT[{vol, 1'b0} +: 2]) + VOL_OFS[{vol, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/lr35902_snd_wave_if.sv
// CPU access bus for the wave RAM (FF30-FF3F).
//  wram_adr   byte address          wram_din   write data
//  wram_write one-clk write strobe  wram_read  one-clk read strobe
//  wram_dout  registered read data
interface lr35902_snd_wave_if;
  logic [3:0] wram_adr;
  logic [7:0] wram_din;
  logic       wram_write;
  logic       wram_read;
  logic [7:0] wram_dout;

  modport master (output wram_adr, wram_din, wram_write, wram_read, input wram_dout);
  modport slave  (input wram_adr, wram_din, wram_write, wram_read, output wram_dout);
endinterface

// File: rtl/lr35902_snd_wram.sv
// 16x8 wave RAM.
//  clk, reset  clock / sync active-high reset (clears all bytes, rdata=FF)
//  we/wadr/wdata    write port
//  re/radr/rdata    registered read port, rdata held between reads
//  peek_adr/peek_data  combinational view used by the sample fetch; it sees
//                      the byte as it was before a same-cycle write
module lr35902_snd_wram (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] wadr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [3:0] radr,
  output logic [7:0] rdata,
  input  logic [3:0] peek_adr,
  output logic [7:0] peek_data
);
  logic [15:0][7:0] mem;

  assign peek_data = mem[peek_adr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem   <= '0;
      rdata <= 8'hFF;
    end else begin
      if (we) mem[wadr] <= wdata;
      if (re) rdata <= mem[radr];
    end
  end
endmodule

// File: rtl/lr35902_snd_wave.sv
// Voice 3 (wave) generator.
//  clk, reset   clock / sync active-high reset
//  tick         2 MHz enable        len_tick  256 Hz length strobe
//  dac_ena      NR30.7              len_load/len  NR31 load
//  vol          NR32[6:5]           freq      NR33/NR34 frequency
//  cntlen       NR34.6              trigger   NR34.7 write pulse
//  cpu          wave RAM CPU bus (slave)
//  active       NR52.2              out       4-bit mixer sample, 8 = silence
module lr35902_snd_wave
  import lr35902_snd_pkg::*;
#(
  parameter int LEN_BITS = 9,
  parameter int POS_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        len_tick,
  input  logic        dac_ena,
  input  logic        len_load,
  input  logic [7:0]  len,
  input  logic [1:0]  vol,
  input  logic [10:0] freq,
  input  logic        cntlen,
  input  logic        trigger,
  lr35902_snd_wave_if.slave cpu,
  output logic        active,
  output logic [3:0]  out
);
  logic [10:0]         freq_cnt;
  logic [POS_BITS-1:0] pos, pos_nxt;
  logic [LEN_BITS-1:0] len_cnt;
  logic [3:0]          sample_buf, nib;
  logic [7:0]          play_byte;
  logic [3:0]          ram_adr;
  logic                len_dec;

  assign pos_nxt = pos + 1'b1;
  // While playing, the CPU only ever reaches the byte being played.
  assign ram_adr = active ? pos[POS_BITS-1:1] : cpu.wram_adr;
  // Even positions play the high nibble.
  assign nib     = pos_nxt[0] ? play_byte[3:0] : play_byte[7:4];
  assign len_dec = !len_load && !trigger && len_tick && cntlen && (len_cnt != '0);

  lr35902_snd_wram u_wram (
    .clk       (clk),
    .reset     (reset),
    .we        (cpu.wram_write),
    .wadr      (ram_adr),
    .wdata     (cpu.wram_din),
    .re        (cpu.wram_read),
    .radr      (ram_adr),
    .rdata     (cpu.wram_dout),
    .peek_adr  (pos_nxt[POS_BITS-1:1]),
    .peek_data (play_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_cnt   <= '0;
      pos        <= '0;
      len_cnt    <= '0;
      sample_buf <= '0;
      active     <= 1'b0;
      out        <= SILENCE;
    end else begin
      // Trigger restarts the period; the old sample_buf keeps playing.
      if (trigger) begin
        freq_cnt <= freq;
        pos      <= '0;
      end else if (tick && active) begin
        if (freq_cnt == 11'h7FF) begin
          freq_cnt   <= freq;
          pos        <= pos_nxt;
          sample_buf <= nib;
        end else begin
          freq_cnt <= freq_cnt + 1'b1;
        end
      end

      if (len_load)                 len_cnt <= LEN_BITS'(256) - LEN_BITS'(len);
      else if (trigger)             begin if (len_cnt == '0) len_cnt <= LEN_BITS'(256); end
      else if (len_dec)             len_cnt <= len_cnt - 1'b1;

      if (!dac_ena)                                  active <= 1'b0;
      else if (trigger)                              active <= 1'b1;
      else if (len_dec && len_cnt == LEN_BITS'(1))   active <= 1'b0;

      out <= (active && vol != 2'd0) ? wave_level(sample_buf, vol) : SILENCE;
    end
  end
endmodule

// File: tb/tb_lr35902_snd_wave.sv
module tb_lr35902_snd_wave;
  logic        clk = 0;
  logic        reset, tick, len_tick, dac_ena, len_load, cntlen, trigger;
  logic [7:0]  len;
  logic [1:0]  vol;
  logic [10:0] freq;
  logic        active;
  logic [3:0]  out;
  logic [7:0]  ram_m [16];
  int          checks = 0, errors = 0;

  lr35902_snd_wave_if bus();

  lr35902_snd_wave dut (
    .clk(clk), .reset(reset), .tick(tick), .len_tick(len_tick), .dac_ena(dac_ena),
    .len_load(len_load), .len(len), .vol(vol), .freq(freq), .cntlen(cntlen),
    .trigger(trigger), .cpu(bus), .active(active), .out(out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wram_adr = a; bus.wram_din = d; bus.wram_write = 1; step(); bus.wram_write = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.wram_adr = a; bus.wram_read = 1; step(); bus.wram_read = 0;
  endtask

  task automatic pulse_tick();
    tick = 1; step(); tick = 0;
  endtask

  task automatic pulse_trig();
    trigger = 1; step(); trigger = 0;
  endtask

  task automatic test_reset();
    reset = 1; step(); step(); reset = 0;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %h want 0", active); end
    checks++; if (out !== 4'h8) begin errors++; $display("FAIL reset_out got %h want 8", out); end
    checks++; if (bus.wram_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got %h want FF", bus.wram_dout); end
    rd(4'd0);
    checks++; if (bus.wram_dout !== 8'h00) begin errors++; $display("FAIL reset_ram got %h want 00", bus.wram_dout); end
  endtask

  task automatic test_play();
    logic [4:0] p;
    logic [3:0] exp;
    for (int i = 0; i < 16; i++) begin ram_m[i] = {i[3:0], i[3:0]}; wr(i[3:0], ram_m[i]); end
    freq = 11'h7FE; vol = 2'd1; dac_ena = 1; cntlen = 0;
    pulse_trig(); step();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL play_active got %h want 1", active); end
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL play_first got %h want 0", out); end
    for (int k = 1; k <= 33; k++) begin
      pulse_tick(); pulse_tick(); step();
      p = 5'(k % 32);
      exp = p[0] ? ram_m[p[4:1]][3:0] : ram_m[p[4:1]][7:4];
      checks++; if (out !== exp) begin errors++; $display("FAIL play_pos%0d got %h want %h", p, out, exp); end
    end
  endtask

  task automatic test_length();
    len = 8'hFE; len_load = 1; step(); len_load = 0;
    cntlen = 1; pulse_trig();
    len_tick = 1; step();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL len_tick1 got %h want 1", active); end
    step(); len_tick = 0;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL len_tick2 got %h want 0", active); end
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL len_out_hold got %h want 0", out); end
    step();
    checks++; if (out !== 4'h8) begin errors++; $display("FAIL len_out_silent got %h want 8", out); end
    cntlen = 0; pulse_trig();
    len_tick = 1;
    for (int i = 0; i < 300; i++) step();
    len_tick = 0;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL len_disabled got %h want 1", active); end
    len = 8'hFF; cntlen = 1; len_load = 1; len_tick = 1; step(); len_load = 0;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL len_load_wins got %h want 1", active); end
    step(); len_tick = 0; cntlen = 0;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL len_after_load got %h want 0", active); end
  endtask

  task automatic test_volume();
    ram_m[0] = 8'hCC; wr(4'd0, 8'hCC);
    freq = 11'h7FF; pulse_trig(); pulse_tick();
    vol = 2'd2; step();
    checks++; if (out !== 4'hA) begin errors++; $display("FAIL vol2 got %h want A", out); end
    vol = 2'd3; step();
    checks++; if (out !== 4'h9) begin errors++; $display("FAIL vol3 got %h want 9", out); end
    vol = 2'd0; step();
    checks++; if (out !== 4'h8) begin errors++; $display("FAIL vol0 got %h want 8", out); end
    vol = 2'd1; step();
    checks++; if (out !== 4'hC) begin errors++; $display("FAIL vol1 got %h want C", out); end
  endtask

  task automatic test_cpu_active();
    pulse_trig();
    for (int i = 0; i < 8; i++) pulse_tick();
    rd(4'd7);
    checks++; if (bus.wram_dout !== 8'h44) begin errors++; $display("FAIL act_read_redirect got %h want 44", bus.wram_dout); end
    bus.wram_adr = 4'd0; bus.wram_din = 8'h5A; bus.wram_write = 1; tick = 1; step();
    bus.wram_write = 0; tick = 0; ram_m[4] = 8'h5A;
    rd(4'd0);
    checks++; if (bus.wram_dout !== 8'h5A) begin errors++; $display("FAIL act_write_read got %h want 5A", bus.wram_dout); end
    checks++; if (out !== 4'h4) begin errors++; $display("FAIL act_old_byte got %h want 4", out); end
    dac_ena = 0; step();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL act_stop got %h want 0", active); end
    rd(4'd0);
    checks++; if (bus.wram_dout !== ram_m[0]) begin errors++; $display("FAIL ram0_unchanged got %h want %h", bus.wram_dout, ram_m[0]); end
    rd(4'd4);
    checks++; if (bus.wram_dout !== ram_m[4]) begin errors++; $display("FAIL ram4_written got %h want %h", bus.wram_dout, ram_m[4]); end
  endtask

  task automatic test_trigger();
    dac_ena = 1; freq = 11'h7FE;
    trigger = 1; tick = 1; step(); trigger = 0; tick = 0;
    pulse_tick(); step();
    checks++; if (out !== 4'h4) begin errors++; $display("FAIL trig_tick_first got %h want 4", out); end
    pulse_tick(); step();
    checks++; if (out !== 4'hC) begin errors++; $display("FAIL trig_tick_second got %h want C", out); end
    dac_ena = 0; step();
    pulse_trig();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL trig_no_dac got %h want 0", active); end
    dac_ena = 1; pulse_trig();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL trig_dac got %h want 1", active); end
    dac_ena = 0; step();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL dac_off got %h want 0", active); end
    step();
    checks++; if (out !== 4'h8) begin errors++; $display("FAIL dac_off_out got %h want 8", out); end
  endtask

  task automatic test_reset_play();
    dac_ena = 1; pulse_trig();
    for (int i = 0; i < 3; i++) pulse_tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rp_active got %h want 1", active); end
    reset = 1; trigger = 1; tick = 1; bus.wram_adr = 4'd0; bus.wram_din = 8'h77; bus.wram_write = 1;
    step();
    reset = 0; trigger = 0; tick = 0; bus.wram_write = 0;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rp_active_clr got %h want 0", active); end
    checks++; if (out !== 4'h8) begin errors++; $display("FAIL rp_out got %h want 8", out); end
    checks++; if (bus.wram_dout !== 8'hFF) begin errors++; $display("FAIL rp_dout got %h want FF", bus.wram_dout); end
    rd(4'd0);
    checks++; if (bus.wram_dout !== 8'h00) begin errors++; $display("FAIL rp_ram0 got %h want 00", bus.wram_dout); end
    rd(4'd4);
    checks++; if (bus.wram_dout !== 8'h00) begin errors++; $display("FAIL rp_ram4 got %h want 00", bus.wram_dout); end
  endtask

  initial begin
    reset = 1; tick = 0; len_tick = 0; dac_ena = 0; len_load = 0; cntlen = 0; trigger = 0;
    len = 0; vol = 0; freq = 0;
    bus.wram_adr = 0; bus.wram_din = 0; bus.wram_write = 0; bus.wram_read = 0;
    test_reset();
    test_play();
    test_length();
    test_volume();
    test_cpu_active();
    test_trigger();
    test_reset_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
